// File: rtl/eff_ctrl.sv
// eff_ctrl: debounced footswitch/select front-end for eff_pipe.
// Config changes land only once the pipe has drained.
module eff_ctrl #(
   parameter int N_EFF    = 16,
   parameter int TICK_DIV = 100000,
   parameter int TIMEOUT  = 4096,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_byp,
   input  logic [N_EFF-1:0] sw,
   input  logic             vld_i,
   input  logic             vld_o,
   output logic             en,
   output logic [N_EFF-1:0] sel,
   output logic             upd,
   output logic             busy,
   output logic             err
);

   localparam int NI = N_EFF + 1;
   localparam int PW = $clog2(TICK_DIV);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;

   state_t           st;
   logic [NI-1:0]    s1, s2, h0, h1, h2, db;
   logic [PW-1:0]    pre;
   logic [CNT_W-1:0] cnt;
   logic [TW-1:0]    tmr;
   logic             btn_q, byp, tick, en_nxt, pending;
   logic             drained, tmo, inc, dec, ovf, unf;
   logic [N_EFF-1:0] sel_nxt;

   assign tick    = (pre == PW'(TICK_DIV - 1));
   assign en_nxt  = ~byp;
   assign sel_nxt = db[N_EFF-1:0];
   assign pending = (sel_nxt != sel) || (en_nxt != en);
   assign drained = (cnt == '0) && !vld_i;
   assign tmo     = (tmr == TW'(TIMEOUT - 1));
   assign inc     = vld_i && !vld_o && (cnt != '1);
   assign dec     = vld_o && !vld_i && (cnt != '0);
   assign ovf     = vld_i && !vld_o && (cnt == '1);
   assign unf     = vld_o && !vld_i && (cnt == '0);

   // bit N_EFF carries the footswitch, the rest the select switches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= '0;
         s2    <= '0;
         h0    <= '0;
         h1    <= '0;
         h2    <= '0;
         db    <= '0;
         pre   <= '0;
         btn_q <= 1'b0;
         byp   <= 1'b0;
      end else begin
         s1  <= {btn_byp, sw};
         s2  <= s1;
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) begin
            h0 <= s2;
            h1 <= h0;
            h2 <= h1;
         end
         db    <= (h0 & h1 & h2) | (db & (h0 | h1 | h2));
         btn_q <= db[N_EFF];
         if (db[N_EFF] && !btn_q)
            byp <= ~byp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         unique case (1'b1)
            inc:     cnt <= cnt + 1'b1;
            dec:     cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= IDLE;
         tmr  <= '0;
         en   <= 1'b1;
         sel  <= '0;
         upd  <= 1'b0;
         busy <= 1'b0;
         err  <= 1'b0;
      end else begin
         upd <= 1'b0;
         err <= err | ovf | unf | ((st == DRAIN) && !drained && tmo);
         unique case (st)
            IDLE: begin
               if (pending) begin
                  st   <= DRAIN;
                  busy <= 1'b1;
                  tmr  <= '0;
               end
            end
            DRAIN: begin
               tmr <= tmr + 1'b1;
               if (drained || tmo) begin
                  st  <= APPLY;
                  sel <= sel_nxt;
                  en  <= en_nxt;
                  upd <= 1'b1;
               end
            end
            APPLY: begin
               st   <= IDLE;
               busy <= 1'b0;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eff_ctrl.sv
// tb_eff_ctrl: directed and randomized checks of eff_ctrl
// against a pipe emulator and in-flight sample model.
module tb_eff_ctrl;

   localparam int N  = 16;
   localparam int TD = 4;
   localparam int TO = 16;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         btn_byp = 1'b0;
   logic [N-1:0] sw = '0;
   logic         vld_i = 1'b0;
   logic         vld_o = 1'b0;
   logic         en, upd, busy, err;
   logic [N-1:0] sel;

   int errors = 0;
   int checks = 0;

   // model state
   int           m_cnt = 0;
   logic [8:0]   pl = '0;
   bit           pipe_run = 1'b1;
   bit           chk_drain = 1'b0;
   int           upd_cnt = 0;
   int           last_cnt = 0;
   logic         last_vi = 1'b0;
   logic         last_drain = 1'b0;
   logic         last_upd = 1'b0;
   logic         last_en = 1'b1;
   logic [N-1:0] last_sel = '0;

   always #5 clk = ~clk;

   eff_ctrl #(
      .N_EFF(N), .TICK_DIV(TD), .TIMEOUT(TO), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_byp(btn_byp), .sw(sw),
      .vld_i(vld_i), .vld_o(vld_o), .en(en), .sel(sel),
      .upd(upd), .busy(busy), .err(err)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_last();
      last_cnt   = 0;
      last_vi    = 1'b0;
      last_drain = 1'b0;
      last_upd   = 1'b0;
      last_en    = 1'b1;
      last_sel   = '0;
   endtask

   // per-cycle rule checks, sampled at negedge+1
   task automatic monitor();
      if (upd) begin
         upd_cnt++;
         chk("upd_one_cycle", last_upd, 1'b0);
      end
      if ((sel !== last_sel) || (en !== last_en))
         chk("cfg_chg_with_upd", upd, 1'b1);
      if (chk_drain && last_drain)
         chk("drain_exit", upd, (last_cnt == 0) && !last_vi);
      last_sel   = sel;
      last_en    = en;
      last_upd   = upd;
      last_cnt   = m_cnt;
      last_vi    = vld_i;
      last_drain = busy && !upd;
   endtask

   task automatic cyc(input logic vi, input logic vo);
      @(posedge clk);
      #1;
      if (!rst_n)
         m_cnt = 0;
      else if (vld_i && !vld_o)
         m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      else if (vld_o && !vld_i)
         m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
      pl    = {pl[7:0], vi};
      vld_i = vi;
      vld_o = (pipe_run & pl[8]) | vo;
      @(negedge clk);
      #1;
      monitor();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      btn_byp  = 1'b0;
      sw       = '0;
      vld_i    = 1'b0;
      vld_o    = 1'b0;
      pl       = '0;
      pipe_run = 1'b1;
      m_cnt    = 0;
      clr_last();
      repeat (3) cyc(1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   // dlen counts DRAIN cycles until the APPLY cycle
   task automatic wait_apply(input int maxc, output int dlen,
                             output bit got);
      dlen = 0;
      got  = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         cyc(1'b0, 1'b0);
         if (busy && !upd) dlen++;
         if (upd) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int dlen, u0, gap;
      bit got, seen;
      logic exp_en, vi, nb;
      logic [N-1:0] exp_sel;

      // reset
      do_reset();
      chk("rst_en", en, 1'b1);
      chk("rst_sel", sel, '0);
      chk("rst_upd", upd, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      repeat (10) cyc(1'b0, 1'b0);
      chk("rst_no_upd", upd_cnt, 0);
      chk("rst_idle", busy, 1'b0);

      // idle select change
      chk_drain = 1'b1;
      u0 = upd_cnt;
      sw = 16'h0005;
      wait_apply(18, dlen, got);
      chk("sel_apply_seen", got, 1'b1);
      chk("sel_value", sel, 16'h0005);
      chk("busy_to_upd", dlen, 1);
      repeat (4) cyc(1'b0, 1'b0);
      chk("sel_one_upd", upd_cnt - u0, 1);
      chk("sel_busy_low", busy, 1'b0);

      // bounce rejection
      u0 = upd_cnt;
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) btn_byp = ~btn_byp;
         cyc(1'b0, 1'b0);
      end
      btn_byp = 1'b1;
      repeat (30) cyc(1'b0, 1'b0);
      chk("byp_en", en, 1'b0);
      chk("byp_one_upd", upd_cnt - u0, 1);
      chk("byp_sel_kept", sel, 16'h0005);

      // drain with samples in flight
      sw = 16'h00A0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc(logic'(i % 2 == 0), 1'b0);
         if (busy) begin
            seen = 1'b1;
            break;
         end
      end
      chk("drain_busy", seen, 1'b1);
      chk("drain_sel_old", sel, 16'h0005);
      wait_apply(30, dlen, got);
      chk("drain_apply_seen", got, 1'b1);
      chk("drain_held", dlen >= 7, 1'b1);
      chk("drain_sel_new", sel, 16'h00A0);
      chk("drain_err", err, 1'b0);

      // randomized settings with sparse traffic
      exp_en = 1'b0;
      gap = 20;
      for (int it = 0; it < 6; it++) begin
         exp_sel = N'($urandom);
         nb = logic'($urandom_range(0, 1));
         if (nb && !btn_byp) exp_en = ~exp_en;
         btn_byp = nb;
         sw = exp_sel;
         for (int k = 0; k < 30; k++) begin
            vi = (gap >= 12) && ($urandom_range(0, 4) == 0);
            gap = vi ? 0 : gap + 1;
            cyc(vi, 1'b0);
         end
         repeat (30) cyc(1'b0, 1'b0);
         gap = 30;
         chk("rnd_sel", sel, exp_sel);
         chk("rnd_en", en, exp_en);
         chk("rnd_err", err, 1'b0);
         chk("rnd_idle", busy, 1'b0);
      end

      // timeout with stuck samples
      chk_drain = 1'b0;
      do_reset();
      pipe_run = 1'b0;
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("to_err_pre", err, 1'b0);
      sw = 16'h1234;
      wait_apply(50, dlen, got);
      chk("to_apply_seen", got, 1'b1);
      chk("to_drain_len", dlen, TO);
      chk("to_sel", sel, 16'h1234);
      chk("to_err", err, 1'b1);
      repeat (5) cyc(1'b0, 1'b0);
      chk("to_err_sticky", err, 1'b1);

      // asynchronous reset while draining
      sw = 16'h00FF;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cyc(1'b0, 1'b0);
         if (busy) begin
            seen = 1'b1;
            break;
         end
      end
      chk("mid_busy", seen, 1'b1);
      repeat (3) cyc(1'b0, 1'b0);
      rst_n = 1'b0;
      sw = '0;
      #1;
      chk("mid_rst_en", en, 1'b1);
      chk("mid_rst_sel", sel, '0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      u0 = upd_cnt;
      do_reset();
      repeat (20) cyc(1'b0, 1'b0);
      chk("mid_rst_no_upd", upd_cnt - u0, 0);

      // counter boundaries
      chk_drain = 1'b1;
      pipe_run = 1'b0;
      repeat (3) cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      chk("both_err", err, 1'b0);
      sw = 16'h0001;
      wait_apply(30, dlen, got);
      chk("both_apply_seen", got, 1'b1);
      chk("both_cnt_zero", dlen, 1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      chk("unf_err", err, 1'b1);
      sw = 16'h0003;
      wait_apply(30, dlen, got);
      chk("unf_apply_seen", got, 1'b1);
      chk("unf_cnt_zero", dlen, 1);

      chk_drain = 1'b0;
      do_reset();
      pipe_run = 1'b0;
      repeat (CMAX) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("sat_err_pre", err, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("sat_err", err, 1'b1);
      repeat (CMAX - 1) cyc(1'b0, 1'b1);
      sw = 16'h0007;
      wait_apply(50, dlen, got);
      chk("sat_apply_seen", got, 1'b1);
      chk("sat_cnt_one", dlen, TO);
      chk("sat_sel", sel, 16'h0007);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eff_ctrl.md
# eff_ctrl

Configuration controller for `eff_pipe`. It debounces the raw footswitch and effect-select switches and owns the pipe's `en`/`sel` inputs. Configuration changes are applied only when no sample is in flight through the pipe, so a sample is never processed half under the old setting and half under the new one. It sits between board I/O and `eff_pipe` in the top level and observes the pipe's `vld_i`/`vld_o` strobes.

## Interface
- `N_EFF`, 16, number of effect select bits; equals the width of `eff_pipe.sel`.
- `TICK_DIV`, 100000, clock cycles between debounce sampling ticks; must be ≥ 2.
- `TIMEOUT`, 4096, maximum cycles spent in DRAIN before a forced apply; must be ≥ 2.
- `CNT_W`, 4, width of the in-flight sample counter.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_byp`  in  1  raw bypass footswitch; asynchronous to `clk`, bouncy.
- `sw`  in  N_EFF  raw effect-enable switches; asynchronous to `clk`, bouncy.
- `vld_i`  in  1  copy of the strobe driven into `eff_pipe.vld_i`.
- `vld_o`  in  1  `eff_pipe.vld_o`.
- `en`  out  1  drives `eff_pipe.en`. 1 = effects active, 0 = bypass.
- `sel`  out  N_EFF  drives `eff_pipe.sel`.
- `upd`  out  1  one-cycle pulse when a new `en`/`sel` takes effect.
- `busy`  out  1  high while the FSM is in DRAIN or APPLY.
- `err`  out  1  sticky error flag; cleared only by reset.

## Operation
- **Synchronizers:** 2-flop synchronizer on `btn_byp` and on every bit of `sw`.
- **Debounce tick:** a prescaler asserts `tick` for one cycle every `TICK_DIV` cycles.
- **Debounce filter:** on each tick, every synchronized input shifts into a 3-deep history. The debounced level updates only when all 3 history entries agree; otherwise it holds.
- **Bypass toggle:** a rising edge of debounced `btn_byp` toggles the `byp` register. The target enable is `en_nxt = ~byp`.
- **Target select:** `sel_nxt` is the debounced `sw`.
- **Pending:** `pending = (sel_nxt != sel) || (en_nxt != en)`.
- **In-flight counter `cnt`:**
  - +1 on `vld_i`, −1 on `vld_o`; no change when both or neither are asserted.
  - Saturates at 2^CNT_W−1 and sets `err`.
  - `vld_o` with `cnt==0` (and no `vld_i`) keeps `cnt` at 0 and sets `err`.
- **FSM:**
  - IDLE: if `pending`, go to DRAIN and clear the drain timer.
  - DRAIN: timer increments each cycle. Go to APPLY when `cnt==0 && !vld_i`, or when the timer reaches `TIMEOUT−1` (forced apply; sets `err`).
  - APPLY: go to IDLE unconditionally.
- **Output load:** `sel`/`en` load `sel_nxt`/`en_nxt` on the DRAIN→APPLY edge, using the values present in the last DRAIN cycle.
- **Re-entry:** if the inputs changed again during APPLY, `pending` re-asserts and IDLE re-enters DRAIN on the next cycle.

## Timing
- **Reset values:**
  - Outputs: `en=1`, `sel=0`, `upd=0`, `busy=0`, `err=0`.
  - Internal: FSM in IDLE, `cnt=0`, `byp=0`, histories and debounced levels 0, prescaler 0.
- **Reset mid-operation:** asserting `rst_n` low in any state returns everything to the reset values immediately (asynchronous). No `upd` pulse is produced.
- **Debounce latency:** from a clean input edge to the debounced change is 2 synchronizer cycles plus 3 to 4 ticks, i.e. at most 2 + 4·TICK_DIV cycles.
- **Apply latency, pipe idle:** with `pending` first high in IDLE at cycle t:
  - cycle t+1: DRAIN;
  - cycle t+2: APPLY, with new `sel`/`en` visible and `upd=1`;
  - cycle t+3: IDLE, `upd=0`.
- **Apply latency, samples in flight:** APPLY occurs in the cycle after the first DRAIN cycle that has `cnt==0 && !vld_i`.
- **`busy`:** asserted in DRAIN and APPLY cycles only.
- **`vld_i` on the DRAIN exit cycle:** blocks exit that cycle.
- **`vld_i` in the APPLY cycle:** that sample is processed with the new configuration; this is legal.
- **Debounced change during DRAIN:** the latest target is applied; no extra pass through the FSM.
- **Debounced change during APPLY:** handled by a second DRAIN/APPLY pass.

## Test plan
Benches use `TICK_DIV=4`, `TIMEOUT=16`, `CNT_W=4`.

- **Reset:** hold `rst_n=0` for 3 cycles, release with all inputs 0 → `en=1`, `sel=0`, `upd`, `busy` and `err` all 0; `upd` never pulses.
- **Idle select change:** drive `sw=16'h0005` steady, no `vld_i` → within 2+16 cycles `sel=16'h0005` and `upd` pulses exactly once; the gap from `busy` rising to `upd` is 1 cycle.
- **Bounce rejection:** toggle `btn_byp` every 3 cycles for 40 cycles, then hold it at 1 → exactly one toggle results: `en=0` after settling, one `upd` pulse.
- **Drain:** put 3 `vld_i` pulses in flight (pipe latency 8), change `sw` → `sel` holds until the 3rd `vld_o`, then APPLY occurs 1 cycle later with `err=0`.
- **Timeout:** stop `vld_o` with `cnt=2`, change `sw` → forced APPLY after 16 DRAIN cycles, `err=1` and stays 1.
- **Counter boundaries:** same-cycle `vld_i` + `vld_o` leaves `cnt` unchanged; `vld_o` at `cnt=0` sets `err` and `cnt` stays 0; 16 `vld_i` with no `vld_o` saturates `cnt` at 15 and sets `err`.
